// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// One result bit per CALC cycle; start/busy/done handshake toward control.
// Optional: define MULT_DIV_EARLY_OUT_EN to let multiplies finish as soon as
// the remaining multiplier bits are all zero.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned DW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_d;
  logic             load, iter, finish, move_hi, move_lo;
  logic             early_out_c;

  logic [1:0]       op_q;
  logic [DW-1:0]    a_q;      // multiplicand (shifting left) / dividend-quotient
  logic [DW-1:0]    acc;      // product accumulator / remainder in low half
  logic [WIDTH-1:0] b_q;      // multiplier (shifting right) / divisor
  logic [CNT_W-1:0] cnt;
  logic             neg_res, neg_rem, dz_q;

  // Operand magnitudes and signs for the request on the inputs
  logic             rs_neg_c, rt_neg_c;
  logic [WIDTH-1:0] rs_mag_c, rt_mag_c;

  always_comb begin
    rs_neg_c = op[0] & rs_data[WIDTH-1];
    rt_neg_c = op[0] & rt_data[WIDTH-1];
    rs_mag_c = rs_neg_c ? (~rs_data + WIDTH'(1)) : rs_data;
    rt_mag_c = rt_neg_c ? (~rt_data + WIDTH'(1)) : rt_data;
  end

  // One restoring-division step and one shift-add multiply step
  logic [WIDTH:0]   shifted_c, diff_c;
  logic             q_bit_c;
  logic [DW-1:0]    prod_sum_c;

  always_comb begin
    shifted_c  = {acc[WIDTH-1:0], a_q[WIDTH-1]};
    diff_c     = shifted_c - {1'b0, b_q};
    q_bit_c    = (shifted_c >= {1'b0, b_q});
    prod_sum_c = acc + (b_q[0] ? a_q : '0);
  end

  // Sign-corrected results presented in FIX
  logic [DW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quot_fix_c, rem_fix_c;

  always_comb begin
    prod_fix_c = neg_res ? (~acc + DW'(1)) : acc;
    quot_fix_c = dz_q ? '1 :
                 (neg_res ? (~a_q[WIDTH-1:0] + WIDTH'(1)) : a_q[WIDTH-1:0]);
    rem_fix_c  = neg_rem ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
  end

`ifdef MULT_DIV_EARLY_OUT_EN
  // Multiply is complete once no multiplier bits remain
  assign early_out_c = ~op_q[1] & (b_q == '0);
`else
  assign early_out_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state;
    load    = 1'b0;
    iter    = 1'b0;
    finish  = 1'b0;
    move_hi = 1'b0;
    move_lo = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CALC;
        end else begin
          move_hi = mthi;
          move_lo = mtlo;
        end
      end
      CALC: begin
        if (early_out_c) begin
          state_d = FIX;
        end else begin
          iter = 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= '0;
      a_q     <= '0;
      acc     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
    end else if (load) begin
      op_q    <= op;
      a_q     <= {WIDTH'(0), rs_mag_c};
      acc     <= '0;
      b_q     <= rt_mag_c;
      cnt     <= '0;
      neg_res <= rs_neg_c ^ rt_neg_c;
      neg_rem <= rs_neg_c;
      dz_q    <= op[1] & (rt_data == '0);
    end else if (iter) begin
      cnt <= cnt + CNT_W'(1);
      if (op_q[1]) begin
        acc <= {WIDTH'(0), q_bit_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0]};
        a_q <= {a_q[DW-2:0], q_bit_c};
      end else begin
        acc <= prod_sum_c;
        a_q <= {a_q[DW-2:0], 1'b0};
        b_q <= b_q >> 1;
      end
    end
  end

  // Registered handshake outputs and HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      busy        <= (state_d != IDLE);
      done        <= finish;
      div_by_zero <= finish & dz_q;
      if (finish) begin
        if (op_q[1]) begin
          hi <= rem_fix_c;
          lo <= quot_fix_c;
        end else begin
          hi <= prod_fix_c[DW-1:WIDTH];
          lo <= prod_fix_c[WIDTH-1:0];
        end
      end else begin
        if (move_hi) hi <= rs_data;
        if (move_lo) lo <= rs_data;
      end
    end
  end

endmodule
